dual_port_ram_param: RTL



---
 rtl/dpram_pkg.sv | 17 +
 rtl/dual_port_ram_param_init_ctrl.sv | 57 +++++
 rtl/dual_port_ram_param.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dpram_pkg.sv
// Shared constants and the init-sequencer state type for the parametrised dual-port RAM.
package dpram_pkg;

    localparam int unsigned COLL_A_WINS = 0;
    localparam int unsigned COLL_B_WINS = 1;
    localparam int unsigned COLL_DROP   = 2;

    localparam int unsigned RD_OLD = 0;
    localparam int unsigned RD_NEW = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } init_state_t;

endpackage

// File: rtl/dual_port_ram_param_init_ctrl.sv
// Post-reset clear sequencer: walks every address once, writing zero, then releases the ports.
module dpram_init_ctrl
    import dpram_pkg::*;
#(
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clear_addr,
    output logic              init_busy
);

    init_state_t       state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // IDLE already clears address 0 on the first cycle out of reset, so the
    // whole clear spans exactly DEPTH cycles after rst falls.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clear_we   = 1'b0;
        clear_addr = cnt;
        init_busy  = 1'b1;
        case (state)
            IDLE: begin
                clear_we   = ~rst;
                state_next = CLEAR;
                cnt_next   = ADDR_W'(1);
            end
            CLEAR: begin
                clear_we = ~rst;
                cnt_next = cnt + 1'b1;
                if (cnt == '1) begin
                    state_next = READY;
                end
            end
            READY: begin
                init_busy = 1'b0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/dual_port_ram_param.sv
// True dual-port RAM with selectable read latency, write-write collision policy,
// read-during-write mode, post-reset clear and a saturating collision counter.
module dual_port_ram_param
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned ADDR_W      = 2,
    parameter int unsigned READ_LAT    = 1,
    parameter int unsigned COLL_POLICY = COLL_A_WINS,
    parameter int unsigned RD_MODE     = RD_OLD,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_A,
    input  logic              R_W_A,
    input  logic [ADDR_W-1:0] address_A,
    input  logic [DATA_W-1:0] data_in_A,
    output logic [DATA_W-1:0] data_out_A,
    output logic              valid_A,
    input  logic              en_B,
    input  logic              R_W_B,
    input  logic [ADDR_W-1:0] address_B,
    input  logic [DATA_W-1:0] data_in_B,
    output logic [DATA_W-1:0] data_out_B,
    output logic              valid_B,
    output logic              init_busy,
    output logic              collision,
    output logic              rw_collision,
    output logic [CNT_W-1:0]  coll_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clear_we;
    logic [ADDR_W-1:0] clear_addr;

    dpram_init_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_init (
        .clk        (clk),
        .rst        (rst),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .init_busy  (init_busy)
    );

    // Index 0 is port A, index 1 is port B.
    logic [1:0]             en, rw, acc, wr, rd, commit;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] din, rdata;
    logic                   same, ww, rw_hit;

    assign en   = {en_B, en_A};
    assign rw   = {R_W_B, R_W_A};
    assign addr = {address_B, address_A};
    assign din  = {data_in_B, data_in_A};

    always_comb begin
        acc    = en & {2{~init_busy & ~rst}};
        wr     = acc & rw;
        rd     = acc & ~rw;
        same   = (addr[0] == addr[1]);
        ww     = wr[0] & wr[1] & same;
        rw_hit = same & ((wr[0] & rd[1]) | (wr[1] & rd[0]));
        commit[0] = wr[0] & ~(ww & (COLL_POLICY != COLL_A_WINS));
        commit[1] = wr[1] & ~(ww & (COLL_POLICY != COLL_B_WINS));
        rdata[0] = (RD_MODE == RD_NEW && wr[1] && same) ? din[1] : mem[addr[0]];
        rdata[1] = (RD_MODE == RD_NEW && wr[0] && same) ? din[0] : mem[addr[1]];
    end

    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end
        if (commit[0]) begin
            mem[addr[0]] <= din[0];
        end
        if (commit[1]) begin
            mem[addr[1]] <= din[1];
        end
    end

    logic [1:0]             src_v;
    logic [1:0][DATA_W-1:0] src_d;

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [1:0]             s1_v;
            logic [1:0][DATA_W-1:0] s1_d;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_v <= '0;
                    s1_d <= '0;
                end else begin
                    s1_v <= rd;
                    s1_d <= rdata;
                end
            end

            assign src_v = s1_v;
            assign src_d = s1_d;
        end else begin : g_lat1
            assign src_v = rd;
            assign src_d = rdata;
        end
    endgenerate

    // Output data only refreshes on a valid result and otherwise holds.
    logic [1:0]             out_v;
    logic [1:0][DATA_W-1:0] out_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_v <= '0;
            out_d <= '0;
        end else begin
            out_v <= src_v;
            for (int unsigned p = 0; p < 2; p++) begin
                if (src_v[p]) begin
                    out_d[p] <= src_d[p];
                end
            end
        end
    end

    assign valid_A    = out_v[0];
    assign valid_B    = out_v[1];
    assign data_out_A = out_d[0];
    assign data_out_B = out_d[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            collision    <= 1'b0;
            rw_collision <= 1'b0;
            coll_count   <= '0;
        end else begin
            collision    <= ww;
            rw_collision <= rw_hit;
            if (ww && coll_count != '1) begin
                coll_count <= coll_count + 1'b1;
            end
        end
    end

endmodule
